// File: rtl/inv_pkg.sv
// Shared definitions for the Gauss-Jordan inversion sequencer.
package inv_pkg;

    // Default matrix order and matching index width
    localparam int unsigned DefN    = 3;
    localparam int unsigned DefIdxW = 2;

    // Micro-op codes driven to the datapath
    localparam logic [1:0] OP_CHK  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_NORM = 2'b10;
    localparam logic [1:0] OP_ELIM = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StDone  = 2'b11
    } state_e;

    // Phase of the current micro-op; encoded as its op code so it drives op_code directly
    typedef enum logic [1:0] {
        PhChk  = OP_CHK,
        PhSwap = OP_SWAP,
        PhNorm = OP_NORM,
        PhElim = OP_ELIM
    } phase_e;

endpackage

// File: rtl/inv_gj_sequencer.sv
// Gauss-Jordan control sequencer: walks pivots p and rows r, issuing CHK/SWAP/NORM/ELIM
// micro-ops to the datapath over a valid/ready + done handshake.
module inv_gj_sequencer
    import inv_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned IDX_W = DefIdxW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             singular_o,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic [1:0]       op_code_o,
    output logic [IDX_W-1:0] op_row_o,
    output logic [IDX_W-1:0] op_piv_o,
    input  logic             op_done_i,
    input  logic             op_zero_i
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   OneExt  = {{IDX_W{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [IDX_W-1:0] p_q, p_d;
    logic [IDX_W-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sing_q, sing_d;
    logic             valid_q, valid_d;
    logic [IDX_W:0]   elim_nxt;
    logic             end_seq;

    // Next-state: sequence walk over (phase, p, r) plus handshake control
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        p_d      = p_q;
        r_d      = r_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sing_d   = sing_q;
        valid_d  = valid_q;
        end_seq  = 1'b0;
        // Next elimination row, stepping over the pivot row; one bit wider to see overflow
        elim_nxt = {1'b0, r_q} + OneExt;
        if (elim_nxt == {1'b0, p_q}) begin
            elim_nxt = elim_nxt + OneExt;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sing_d  = 1'b0;
                    p_d     = '0;
                    r_d     = '0;
                    phase_d = PhChk;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (op_ready_i) begin
                    valid_d = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (op_done_i) begin
                    state_d = StIssue;
                    valid_d = 1'b1;
                    unique case (phase_q)
                        PhChk: begin
                            if (!op_zero_i) begin
                                // Non-zero on the diagonal normalises; found below needs a swap
                                phase_d = (r_q == p_q) ? PhNorm : PhSwap;
                            end else if (r_q == LastIdx) begin
                                sing_d  = 1'b1;
                                end_seq = 1'b1;
                            end else begin
                                r_d = r_q + IDX_W'(1);
                            end
                        end
                        PhSwap: begin
                            phase_d = PhNorm;
                            r_d     = p_q;
                        end
                        PhNorm: begin
                            phase_d = PhElim;
                            r_d     = (p_q == '0) ? IDX_W'(1) : '0;
                        end
                        PhElim: begin
                            if (elim_nxt <= {1'b0, LastIdx}) begin
                                r_d = elim_nxt[IDX_W-1:0];
                            end else if (p_q != LastIdx) begin
                                phase_d = PhChk;
                                p_d     = p_q + IDX_W'(1);
                                r_d     = p_q + IDX_W'(1);
                            end else begin
                                end_seq = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: ;
        endcase

        if (end_seq) begin
            state_d = StDone;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        // Abort wins over any progress; singular keeps its value
        if (abort_i) begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            sing_d  = sing_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            phase_q <= PhChk;
            p_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sing_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            p_q     <= p_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sing_q  <= sing_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign singular_o = sing_q;
    assign op_valid_o = valid_q;
    assign op_code_o  = phase_q;
    assign op_row_o   = r_q;
    assign op_piv_o   = p_q;

endmodule
